// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial_adder block: FSM state encoding and
// a constant clog2 used to size the step counter.
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; chained CHUNK times per serial_adder step.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per cycle, valid/ready on both sides.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input for a - b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSTEP = WIDTH / CHUNK;
  localparam int CW    = clog2(NSTEP) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CW-1:0]    step_q;
  logic             last_step;

  logic [WIDTH-1:0] b_init;
  logic             carry_init;
  logic [CHUNK-1:0] chunk_s;
  logic [CHUNK:0]   c;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and force the initial carry to 1.
  assign b_init     = sub ? ~b : b;
  assign carry_init = sub | cin;
`else
  assign b_init     = b;
  assign carry_init = cin;
`endif

  assign c[0] = carry_q;

  for (genvar i = 0; i < CHUNK; i++) begin : g_ripple
    fa_cell u_fa (
      .a  (a_q[i]),
      .b  (b_q[i]),
      .ci (c[i]),
      .s  (chunk_s[i]),
      .co (c[i+1])
    );
  end

  assign last_step = (step_q == CW'(NSTEP - 1));

  // NOTE: async reset in the sensitivity list; sequential state uses <= only
  // so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_init;
            carry_q <= carry_init;
            step_q  <= '0;
          end
        end
        RUN: begin
          // Result chunks enter at the MSB end so the first chunk ends up lowest.
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          sum_q   <= (sum_q >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));
          carry_q <= c[CHUNK];
          step_q  <= step_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (CHUNK=1, 4, 8),
// directed vector table, multi-cycle corner sequences and random ops.
module tb_serial_adder;

  localparam int W  = 8;
  localparam int ND = 3;

  typedef struct {
    int         d;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid [ND];
  logic         in_ready [ND];
  logic         cin_s    [ND];
  logic         out_valid[ND];
  logic         out_ready[ND];
  logic         cout_o   [ND];
  logic         busy_o   [ND];
  logic [W-1:0] a_s      [ND];
  logic [W-1:0] b_s      [ND];
  logic [W-1:0] sum_o    [ND];
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub_s    [ND];
`endif

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s[0]),
`endif
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .sum(sum_o[0]), .cout(cout_o[0]), .busy(busy_o[0]));

  serial_adder #(.WIDTH(8), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s[1]),
`endif
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .sum(sum_o[1]), .cout(cout_o[1]), .busy(busy_o[1]));

  serial_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_s[2]), .b(b_s[2]), .cin(cin_s[2]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s[2]),
`endif
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .sum(sum_o[2]), .cout(cout_o[2]), .busy(busy_o[2]));

  function automatic int nstep(input int d);
    case (d)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer arithmetic; subtraction as a + ~b + 1.
  function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic cv, input logic sv);
    logic [8:0] bb;
    bb = sv ? {1'b0, ~bv} : {1'b0, bv};
    return {1'b0, av} + bb + (sv ? 9'd1 : {8'd0, cv});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_ops(input int d, input logic [7:0] av, input logic [7:0] bv,
                           input logic cv, input logic sv);
    a_s[d]   = av;
    b_s[d]   = bv;
    cin_s[d] = cv;
`ifdef SERIAL_ADDER_SUB_EN
    sub_s[d] = sv;
`else
    if (sv) $display("sub requested without SERIAL_ADDER_SUB_EN");
`endif
  endtask

  // Called at a negedge; full accept / compute / retire transaction.
  task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic sv, input logic [8:0] exp,
                        input string name);
    int lat;
    lat = 0;
    while (!in_ready[d] && lat < 64) begin @(negedge clk); lat++; end
    check({name, "_in_ready"}, 32'(in_ready[d]), 32'd1);
    drive_ops(d, av, bv, cv, sv);
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    // Operand changes during RUN must not matter.
    drive_ops(d, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    lat = 0;
    while (!out_valid[d] && lat < 64) begin @(negedge clk); lat++; end
    check({name, "_latency"}, 32'(lat), 32'(nstep(d)));
    check({name, "_result"}, {23'd0, cout_o[d], sum_o[d]}, {23'd0, exp});
    check({name, "_busy_in_ready"}, {30'd0, busy_o[d], in_ready[d]}, 32'b10);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check({name, "_retire"}, {29'd0, in_ready[d], out_valid[d], busy_o[d]}, 32'b100);
  endtask

  vec_t vecs[$];

  initial begin
    logic [7:0] ra, rb;
    logic       rc, rs;
    int         rd, lat;
    bit         saw_valid;

    vecs.push_back('{0, 8'hA5, 8'h3C, 1'b0, 1'b0, 9'h0E1});
    vecs.push_back('{0, 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100});
    vecs.push_back('{1, 8'h7F, 8'h80, 1'b1, 1'b0, 9'h100});
    vecs.push_back('{2, 8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF});
    vecs.push_back('{2, 8'h00, 8'h00, 1'b1, 1'b0, 9'h001});
    vecs.push_back('{1, 8'h80, 8'h80, 1'b0, 1'b0, 9'h100});
    vecs.push_back('{0, 8'h0F, 8'hF0, 1'b1, 1'b0, 9'h100});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{0, 8'h10, 8'h20, 1'b0, 1'b1, 9'h0F0});
    vecs.push_back('{0, 8'h20, 8'h10, 1'b1, 1'b1, 9'h110});
    vecs.push_back('{1, 8'h10, 8'h20, 1'b1, 1'b1, 9'h0F0});
`endif

    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      drive_ops(d, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    #12;
    for (int d = 0; d < ND; d++)
      check($sformatf("reset_state_%0d", d),
            {19'd0, in_ready[d], out_valid[d], busy_o[d], cout_o[d], sum_o[d]},
            {19'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp,
             $sformatf("vec%0d", i));

    // Backpressure: result held in DONE while new operands are offered.
    drive_ops(0, 8'h5A, 8'h33, 1'b0, 1'b0);
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 64) begin @(negedge clk); lat++; end
    check("bp_latency", 32'(lat), 32'd8);
    for (int k = 0; k < 5; k++) begin
      drive_ops(0, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
      in_valid[0] = 1'b1;
      @(negedge clk);
      check($sformatf("bp_hold_%0d", k),
            {21'd0, in_ready[0], out_valid[0], cout_o[0], sum_o[0]},
            {21'd0, 1'b0, 1'b1, 1'b0, 8'h8D});
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check("bp_release", {30'd0, in_ready[0], out_valid[0]}, 32'b10);

    // Reset in the middle of an 8-step add.
    drive_ops(0, 8'hF0, 8'h0F, 1'b1, 1'b0);
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_mid_async",
             {20'd0, in_ready[0], out_valid[0], busy_o[0], cout_o[0], sum_o[0]},
             {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    check("rst_mid_held",
          {20'd0, in_ready[0], out_valid[0], busy_o[0], cout_o[0], sum_o[0]},
          {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid[0] || !in_ready[0]) saw_valid = 1'b1;
    end
    check("rst_no_out_valid", 32'(saw_valid), 32'd0);
    run_op(0, 8'h01, 8'h02, 1'b0, 1'b0, 9'h003, "post_rst");

    // Random operations across all chunk sizes.
    for (int n = 0; n < 30; n++) begin
      rd = n % ND;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(rd, ra, rb, rc, rs, model(ra, rb, rc, rs), $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
